// File: rtl/prime_sweep_ctrl.sv
// Sweeps a contiguous range of 3-bit codes through the prime evaluator and collects P samples.
// Optional golden compare against primes {2,3,5,7} enabled by PRIME_SWEEP_GOLDEN_CHECK_EN.
module prime_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned START_VAL     = 0,
   parameter int unsigned END_VAL       = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       eval_c,
   output logic       eval_b,
   output logic       eval_a,
   input  logic       eval_p,
   output logic       busy,
   output logic       done,
   output logic [7:0] prime_map,
   output logic [3:0] prime_count,
   output logic       mismatch
);

   localparam int unsigned SettleW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [SettleW-1:0] SettleInit = SettleW'(SETTLE_CYCLES);
   localparam logic [2:0] StartIdx = 3'(START_VAL);
   localparam logic [2:0] EndIdx   = 3'(END_VAL);

   generate
      if (START_VAL > 7 || END_VAL > 7 || END_VAL < START_VAL) begin : g_bad_range
         $error("prime_sweep_ctrl: illegal START_VAL/END_VAL combination");
      end
   endgenerate

   typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

   state_e               state_q;
   logic [2:0]           idx_q;
   logic [SettleW-1:0]   settle_q;
   logic [7:0]           prime_map_q;
   logic [3:0]           prime_count_q;

`ifdef PRIME_SWEEP_GOLDEN_CHECK_EN
   localparam logic [7:0] GoldenMap = 8'hAC;
   logic mismatch_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         settle_q      <= '0;
         prime_map_q   <= '0;
         prime_count_q <= '0;
`ifdef PRIME_SWEEP_GOLDEN_CHECK_EN
         mismatch_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q       <= StDrive;
                  idx_q         <= StartIdx;
                  settle_q      <= SettleInit;
                  prime_map_q   <= '0;
                  prime_count_q <= '0;
`ifdef PRIME_SWEEP_GOLDEN_CHECK_EN
                  mismatch_q    <= 1'b0;
`endif
               end
            end
            StDrive: begin
               if (settle_q == '0) begin
                  state_q <= StSample;
               end else begin
                  settle_q <= settle_q - 1'b1;
               end
            end
            StSample: begin
               prime_map_q[idx_q] <= eval_p;
               prime_count_q      <= prime_count_q + {3'b000, eval_p};
`ifdef PRIME_SWEEP_GOLDEN_CHECK_EN
               if (eval_p != GoldenMap[idx_q]) begin
                  mismatch_q <= 1'b1;
               end
`endif
               // Terminal code goes straight to DONE so idx never wraps.
               if (idx_q == EndIdx) begin
                  state_q <= StDone;
               end else begin
                  idx_q    <= idx_q + 3'd1;
                  settle_q <= SettleInit;
                  state_q  <= StDrive;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      busy = (state_q != StIdle);
      done = (state_q == StDone);
      if (state_q == StDrive || state_q == StSample) begin
         {eval_c, eval_b, eval_a} = idx_q;
      end else begin
         {eval_c, eval_b, eval_a} = 3'b000;
      end
   end

   assign prime_map   = prime_map_q;
   assign prime_count = prime_count_q;
`ifdef PRIME_SWEEP_GOLDEN_CHECK_EN
   assign mismatch    = mismatch_q;
`else
   assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_prime_sweep_ctrl.sv
// Bench for prime_sweep_ctrl: default-parameter sweeps from a vector table with a scoreboard,
// plus a narrowed-range instance and hand-written reset / back-to-back sequences.
module tb_prime_sweep_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, start2, stuck;
   logic       eval_c, eval_b, eval_a, eval_p, busy, done, mismatch;
   logic [7:0] prime_map;
   logic [3:0] prime_count;
   logic       c2, b2, a2, eval_p2, busy2, done2, mismatch2;
   logic [7:0] prime_map2;
   logic [3:0] prime_count2;
   logic [7:0] prime_ref;

`ifdef PRIME_SWEEP_GOLDEN_CHECK_EN
   localparam logic ExpStuckMm = 1'b1;
`else
   localparam logic ExpStuckMm = 1'b0;
`endif

   // Behavioural prime evaluator; stuck forces P=1.
   assign eval_p  = stuck ? 1'b1 : prime_ref[{eval_c, eval_b, eval_a}];
   assign eval_p2 = prime_ref[{c2, b2, a2}];

   prime_sweep_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start),
      .eval_c(eval_c), .eval_b(eval_b), .eval_a(eval_a), .eval_p(eval_p),
      .busy(busy), .done(done), .prime_map(prime_map), .prime_count(prime_count),
      .mismatch(mismatch)
   );

   prime_sweep_ctrl #(.SETTLE_CYCLES(0), .START_VAL(4), .END_VAL(7)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .eval_c(c2), .eval_b(b2), .eval_a(a2), .eval_p(eval_p2),
      .busy(busy2), .done(done2), .prime_map(prime_map2), .prime_count(prime_count2),
      .mismatch(mismatch2)
   );

   typedef struct {
      logic       stuck;
      logic [7:0] map;
      logic [3:0] cnt;
      logic       mm;
      int         edges;
   } vec_t;

   vec_t tbl[3];
   vec_t sb_q[$];
   int   seq2[$];
   int   checks = 0;
   int   failures = 0;

   always @(negedge clk) begin
      if (busy2 && !done2) begin
         if (seq2.size() == 0 || seq2[$] != int'({c2, b2, a2})) seq2.push_back(int'({c2, b2, a2}));
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Waits for done on the default instance; edges=0 means the budget expired.
   task automatic wait_done(input int bound, output int edges);
      edges = 0;
      for (int k = 1; k <= bound; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            edges = k;
            break;
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int   e;
      vec_t exp;
      stuck = v.stuck;
      sb_q.push_back(v);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      check("busy_after_accept", busy, 1);
      wait_done(60, e);
      exp = sb_q.pop_front();
      check("done_edge", e, exp.edges);
      check("prime_map", prime_map, exp.map);
      check("prime_count", prime_count, exp.cnt);
      check("mismatch", mismatch, exp.mm);
      check("busy_in_done", busy, 1);
      check("eval_in_done", {eval_c, eval_b, eval_a}, 0);
      @(negedge clk);
      check("done_width", done, 0);
      check("busy_after_done", busy, 0);
      check("map_held", prime_map, exp.map);
   endtask

   initial begin
      int e;
      int found;
      int done_seen;
      prime_ref = 8'hAC;
      tbl[0] = '{stuck: 1'b0, map: 8'hAC, cnt: 4'd4, mm: 1'b0, edges: 24};
      tbl[1] = '{stuck: 1'b1, map: 8'hFF, cnt: 4'd8, mm: ExpStuckMm, edges: 24};
      tbl[2] = '{stuck: 1'b0, map: 8'hAC, cnt: 4'd4, mm: 1'b0, edges: 24};

      rst = 1'b1; start = 1'b0; start2 = 1'b0; stuck = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_eval", {eval_c, eval_b, eval_a}, 0);
      check("rst_map", prime_map, 0);
      check("rst_count", prime_count, 0);
      check("rst_mismatch", mismatch, 0);

      for (int i = 0; i < 3; i++) run_vec(tbl[i]);

      // Narrow range, zero settle.
      seq2.delete();
      @(negedge clk) start2 = 1'b1;
      @(posedge clk);
      @(negedge clk) start2 = 1'b0;
      e = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done2) begin
            e = k;
            break;
         end
      end
      check("t2_done_edge", e, 8);
      check("t2_map", prime_map2, 8'hA0);
      check("t2_count", prime_count2, 2);
      check("t2_mismatch", mismatch2, 0);
      check("t2_seq_len", seq2.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("t2_seq_code", (i < seq2.size()) ? seq2[i] : 99, 4 + i);
      end

      // Reset while code 3 is being driven.
      stuck = 1'b1;
      done_seen = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      found = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) done_seen = 1;
         if ({eval_c, eval_b, eval_a} == 3'd3) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      check("t4_reached_code3", found, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t4_busy", busy, 0);
      check("t4_map", prime_map, 0);
      check("t4_count", prime_count, 0);
      check("t4_mismatch", mismatch, 0);
      check("t4_eval", {eval_c, eval_b, eval_a}, 0);
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (done || busy) done_seen = 1;
         @(negedge clk);
      end
      check("t4_no_done", done_seen, 0);
      run_vec(tbl[0]);

      // start held high: back-to-back sweeps.
      stuck = 1'b0;
      @(negedge clk) start = 1'b1;
      wait_done(60, e);
      check("t5_first_done", e, 25);
      check("t5_map1", prime_map, 8'hAC);
      e = 0;
      for (int t = 1; t <= 60; t++) begin
         @(posedge clk);
         @(negedge clk);
         if (t == 1) begin
            check("t5_done_width", done, 0);
            check("t5_idle_gap", busy, 0);
         end
         if (t == 2) check("t5_redrive", busy, 1);
         if (done) begin
            e = t;
            break;
         end
      end
      check("t5_spacing", e, 26);
      check("t5_map2", prime_map, 8'hAC);
      check("t5_count2", prime_count, 4);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t5_stop", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
